// File: rtl/multi_port_wb_ram.sv
// -----------------------------------------------------------------------------
// multi_port_wb_ram
// N-port, M-bank pipelined Wishbone RAM. Each port may address any bank; ports
// hitting different banks proceed in parallel, ports colliding on a bank are
// serialised by a per-bank arbiter (round-robin or fixed priority) and the
// losers see wb_stall_o. Reads and writes are accepted at the clock edge where
// stb & !stall; the ack (and read data) appear exactly one cycle later.
//
// Ports:
//   clk        : single clock
//   rst        : asynchronous active-low reset
//   wb_addr_i  : per-port byte address   (port p at slice p)
//   wb_data_i  : per-port write data
//   wb_sel_i   : per-port byte enables
//   wb_we_i    : per-port write enable
//   wb_cyc_i   : per-port bus cycle
//   wb_stb_i   : per-port strobe
//   wb_ack_o   : per-port acknowledge (suppressed when cyc has dropped)
//   wb_data_o  : per-port read data, holds last read value
//   wb_stall_o : per-port stall, combinational from the arbitration
//   VPWR/VGND  : power pins, only with USE_POWER_PINS
// -----------------------------------------------------------------------------
module multi_port_wb_ram #(
  parameter int NUM_PORTS  = 2,
  parameter int NUM_BANKS  = 2,
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8,
  parameter int ARB_RR     = 1
) (
`ifdef USE_POWER_PINS
  inout  wire                             VPWR,
  inout  wire                             VGND,
`endif
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] wb_data_i,
  input  logic [NUM_PORTS*SEL_WIDTH-1:0]  wb_sel_i,
  input  logic [NUM_PORTS-1:0]            wb_we_i,
  input  logic [NUM_PORTS-1:0]            wb_cyc_i,
  input  logic [NUM_PORTS-1:0]            wb_stb_i,
  output logic [NUM_PORTS-1:0]            wb_ack_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] wb_data_o,
  output logic [NUM_PORTS-1:0]            wb_stall_o
);

  localparam int OFF_W  = $clog2(SEL_WIDTH);
  localparam int WORD_W = ADDR_WIDTH - OFF_W;
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int IDX_W  = WORD_W - BANK_W;
  localparam int DEPTH  = 1 << IDX_W;
  localparam int BSEL_W = (BANK_W == 0) ? 1 : BANK_W;
  localparam int PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  // Reject parameter sets the address decode cannot represent.
  generate
    if ((NUM_BANKS & (NUM_BANKS - 1)) != 0) begin : g_bad_banks
      $error("NUM_BANKS must be a power of two");
    end
    if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
      $error("DATA_WIDTH must be a multiple of 8");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] r_mem   [NUM_BANKS][DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata [NUM_PORTS];
  logic [NUM_PORTS-1:0]  r_ack_q;
  logic [PTR_W-1:0]      r_ptr   [NUM_BANKS];

  logic [BSEL_W-1:0]     w_bank  [NUM_PORTS];
  logic [IDX_W-1:0]      w_idx   [NUM_PORTS];
  logic [NUM_PORTS-1:0]  w_req;
  logic [NUM_PORTS-1:0]  w_grant;
  logic [NUM_BANKS-1:0]  w_bank_gnt;
  logic [PTR_W-1:0]      w_win   [NUM_BANKS];

  // Address decode: word address split into bank (top bits) and bank index.
  always_comb begin
    logic [WORD_W-1:0] v_word;
    v_word = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      v_word   = wb_addr_i[p*ADDR_WIDTH+OFF_W +: WORD_W];
      w_idx[p] = v_word[IDX_W-1:0];
      if (BANK_W == 0) begin
        w_bank[p] = '0;
      end else begin
        w_bank[p] = BSEL_W'(v_word >> IDX_W);
      end
      w_req[p] = wb_cyc_i[p] & wb_stb_i[p];
    end
  end

  // Per-bank arbitration: scan ports starting at the RR pointer (or port 0).
  always_comb begin
    int   v_q;
    logic v_found;
    v_q        = 0;
    v_found    = 1'b0;
    w_grant    = '0;
    w_bank_gnt = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_win[b] = '0;
      v_found  = 1'b0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (ARB_RR != 0) begin
          v_q = (int'(r_ptr[b]) + k) % NUM_PORTS;
        end else begin
          v_q = k;
        end
        if (!v_found && w_req[v_q] && (w_bank[v_q] == BSEL_W'(b))) begin
          v_found       = 1'b1;
          w_grant[v_q]  = 1'b1;
          w_bank_gnt[b] = 1'b1;
          w_win[b]      = PTR_W'(v_q);
        end else begin
          v_found = v_found;
        end
      end
    end
  end

  assign wb_stall_o = w_req & ~w_grant;
  // The ack is dropped if the master abandons the cycle before it arrives.
  assign wb_ack_o   = r_ack_q & wb_cyc_i;

  // Output packing of per-port read data.
  always_comb begin
    wb_data_o = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      wb_data_o[p*DATA_WIDTH +: DATA_WIDTH] = r_rdata[p];
    end
  end

  // Round-robin pointers: move past the winner, hold when the bank is idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < NUM_BANKS; b++) r_ptr[b] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (w_bank_gnt[b]) begin
          r_ptr[b] <= PTR_W'((int'(w_win[b]) + 1) % NUM_PORTS);
        end
      end
    end
  end

  // Ack pipeline and read data capture; a read samples the pre-write contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ack_q <= '0;
      for (int p = 0; p < NUM_PORTS; p++) r_rdata[p] <= '0;
    end else begin
      r_ack_q <= w_grant;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_grant[p] && !wb_we_i[p]) begin
          r_rdata[p] <= r_mem[w_bank[p]][w_idx[p]];
        end
      end
    end
  end

  // Memory array: byte-lane writes, at most one granted port per bank.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_grant[p] && wb_we_i[p]) begin
        for (int s = 0; s < SEL_WIDTH; s++) begin
          if (wb_sel_i[p*SEL_WIDTH+s]) begin
            r_mem[w_bank[p]][w_idx[p]][s*8 +: 8] <= wb_data_i[p*DATA_WIDTH+s*8 +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_port_wb_ram.sv
module tb_multi_port_wb_ram;

  localparam int NP = 4;
  localparam int NB = 4;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int SW = 4;

  typedef struct {
    bit          cyc;
    bit          stb;
    bit          we;
    logic [10:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
  } op_t;

  typedef struct {
    int          due;
    bit          we;
    logic [31:0] data;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NP*AW-1:0]   wb_addr_i = '0;
  logic [NP*DW-1:0]   wb_data_i = '0;
  logic [NP*SW-1:0]   wb_sel_i = '0;
  logic [NP-1:0]      wb_we_i = '0;
  logic [NP-1:0]      wb_cyc_i = '0;
  logic [NP-1:0]      wb_stb_i = '0;
  logic [NP-1:0]      wb_ack_o;
  logic [NP*DW-1:0]   wb_data_o;
  logic [NP-1:0]      wb_stall_o;

  multi_port_wb_ram #(
    .NUM_PORTS(NP), .NUM_BANKS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .SEL_WIDTH(SW), .ARB_RR(1)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .wb_sel_i(wb_sel_i),
    .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_ack_o(wb_ack_o), .wb_data_o(wb_data_o), .wb_stall_o(wb_stall_o)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int          n_cmp = 0;
  int          n_bad = 0;
  op_t         opq [NP][$];
  exp_t        expq [NP][$];
  op_t         cur [NP];
  bit          busy [NP];
  logic [31:0] exp_last [NP];
  logic [31:0] mem_m [512];
  int          ptr_m [NB];
  bit          rnd_mode = 1'b0;

  task automatic chk(input string name, input int p, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s port%0d cycle %0d: got %h expected %h", name, p, cyc_n, got, exp);
    end
  endtask

  function automatic op_t mk(input bit we, input int bank, input int idx,
                             input logic [3:0] sel, input logic [31:0] d);
    op_t o;
    o.cyc = 1'b1; o.stb = 1'b1; o.we = we; o.sel = sel; o.data = d;
    o.addr = {bank[1:0], idx[6:0], 2'b00};
    return o;
  endfunction

  function automatic op_t idle(input bit keep_cyc);
    op_t o;
    o.cyc = keep_cyc; o.stb = 1'b0; o.we = 1'b0; o.sel = 4'h0; o.data = 32'h0;
    o.addr = 11'h0;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int  r;
    r = $urandom_range(0, 9);
    if (r < 3) begin
      o = idle(1'($urandom_range(0, 1)));
    end else begin
      o = mk(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 15),
             4'($urandom_range(0, 15)), $urandom);
      o.addr[1:0] = 2'($urandom_range(0, 3));
    end
    return o;
  endfunction

  // Reference model: spec arbitration rules on plain ints, memory as an array.
  task automatic model_eval();
    bit gnt [NP];
    int w;
    for (int p = 0; p < NP; p++) gnt[p] = 1'b0;
    for (int b = 0; b < NB; b++) begin
      for (int k = 0; k < NP; k++) begin
        int q;
        q = (ptr_m[b] + k) % NP;
        if (cur[q].cyc && cur[q].stb && int'(cur[q].addr[10:9]) == b) begin
          gnt[q]   = 1'b1;
          ptr_m[b] = (q + 1) % NP;
          break;
        end
      end
    end
    for (int p = 0; p < NP; p++) begin
      chk("stall", p, 32'(wb_stall_o[p]), 32'(cur[p].cyc && cur[p].stb && !gnt[p]));
    end
    for (int p = 0; p < NP; p++) begin
      if (gnt[p] && !cur[p].we) begin
        w = int'(cur[p].addr[10:2]);
        expq[p].push_back('{due: cyc_n + 1, we: 1'b0, data: mem_m[w]});
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (gnt[p] && cur[p].we) begin
        w = int'(cur[p].addr[10:2]);
        for (int s = 0; s < 4; s++)
          if (cur[p].sel[s]) mem_m[w][s*8 +: 8] = cur[p].data[s*8 +: 8];
        expq[p].push_back('{due: cyc_n + 1, we: 1'b1, data: 32'h0});
      end
      if (gnt[p]) busy[p] = 1'b0;
    end
  endtask

  task automatic drive_cur();
    for (int p = 0; p < NP; p++) begin
      wb_addr_i[p*AW +: AW] = cur[p].addr;
      wb_data_i[p*DW +: DW] = cur[p].data;
      wb_sel_i[p*SW +: SW]  = cur[p].sel;
      wb_we_i[p]  = cur[p].we;
      wb_cyc_i[p] = cur[p].cyc;
      wb_stb_i[p] = cur[p].stb;
    end
  endtask

  task automatic cycle_drive();
    @(posedge clk); #1;
    for (int p = 0; p < NP; p++) begin
      if (!busy[p]) begin
        if (opq[p].size() > 0) cur[p] = opq[p].pop_front();
        else if (rnd_mode)     cur[p] = rand_op();
        else                   cur[p] = idle(1'b0);
        busy[p] = cur[p].cyc && cur[p].stb;
      end
    end
    drive_cur();
    #1;
    model_eval();
  endtask

  // Reset drops in-flight acks and clears read data and RR pointers.
  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int p = 0; p < NP; p++) begin
      expq[p].delete();
      exp_last[p] = 32'h0;
      cur[p] = idle(1'b0);
      busy[p] = 1'b0;
    end
    for (int b = 0; b < NB; b++) ptr_m[b] = 0;
    drive_cur();
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic run_drain();
    int  n;
    bit  pend;
    n = 0;
    do begin
      cycle_drive();
      n++;
      pend = 1'b0;
      for (int p = 0; p < NP; p++) if (busy[p] || opq[p].size() > 0) pend = 1'b1;
    end while (pend && n < 300);
    if (pend) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got pending requests expected none");
    end
    cycle_drive();
  endtask

  // Monitor: pops the scoreboard whenever an ack is due and checks the outputs.
  initial begin
    exp_t e;
    bit   exp_ack;
    forever begin
      @(posedge clk); #3;
      for (int p = 0; p < NP; p++) begin
        exp_ack = 1'b0;
        while (expq[p].size() > 0 && expq[p][0].due < cyc_n) begin
          e = expq[p].pop_front();
          n_cmp++; n_bad++;
          $display("FAIL ack_stale port%0d: got entry due %0d expected due %0d", p, e.due, cyc_n);
        end
        if (expq[p].size() > 0 && expq[p][0].due == cyc_n) begin
          e = expq[p].pop_front();
          exp_ack = wb_cyc_i[p];
          if (!e.we) exp_last[p] = e.data;
        end
        chk("ack", p, 32'(wb_ack_o[p]), 32'(exp_ack));
        chk("rdata", p, wb_data_o[p*DW +: DW], exp_last[p]);
      end
    end
  end

  initial begin
    for (int p = 0; p < NP; p++) begin
      cur[p] = idle(1'b0); busy[p] = 1'b0; exp_last[p] = 32'h0;
    end
    for (int b = 0; b < NB; b++) ptr_m[b] = 0;
    for (int i = 0; i < 512; i++) mem_m[i] = 32'h0;
    drive_cur();
    do_reset(3);

    // Preset the exercised region so every later read has a defined value.
    for (int i = 0; i < 16; i++)
      for (int p = 0; p < NP; p++) opq[p].push_back(mk(1'b1, p, i, 4'hF, $urandom));
    run_drain();

    // Different banks in the same cycle: no stall.
    opq[1].push_back(mk(1'b1, 0, 1, 4'hF, 32'hA5A5A5A5));
    opq[0].push_back(mk(1'b1, 1, 1, 4'hF, 32'h5A5A5A5A));
    run_drain();
    opq[0].push_back(mk(1'b0, 0, 1, 4'hF, 32'h0));
    opq[1].push_back(mk(1'b0, 1, 1, 4'hF, 32'h0));
    run_drain();

    // Same-bank collision, twice, then readback.
    for (int r = 0; r < 2; r++) begin
      opq[0].push_back(mk(1'b1, 0, 2, 4'hF, 32'h12345678));
      opq[1].push_back(mk(1'b1, 0, 3, 4'hF, 32'h87654321));
    end
    run_drain();
    opq[2].push_back(mk(1'b0, 0, 2, 4'hF, 32'h0));
    opq[2].push_back(mk(1'b0, 0, 3, 4'hF, 32'h0));
    run_drain();

    // Byte lanes.
    opq[0].push_back(mk(1'b1, 0, 4, 4'hF, 32'hFFFFFFFF));
    opq[0].push_back(mk(1'b1, 0, 4, 4'h5, 32'h11223344));
    opq[0].push_back(mk(1'b1, 0, 4, 4'h0, 32'h00000000));
    opq[0].push_back(mk(1'b0, 0, 4, 4'hF, 32'h0));
    run_drain();

    // All ports hammer bank 2: grants rotate.
    for (int i = 0; i < 8; i++)
      for (int p = 0; p < NP; p++) opq[p].push_back(mk(1'b0, 2, (i + p) % 16, 4'hF, 32'h0));
    run_drain();

    // Pipelined reads on one port.
    for (int i = 0; i < 4; i++) opq[0].push_back(mk(1'b0, 0, i, 4'hF, 32'h0));
    run_drain();

    // Accepted write whose ack is abandoned still lands.
    opq[3].push_back(mk(1'b1, 3, 5, 4'hF, 32'hC0FFEE00));
    opq[3].push_back(idle(1'b0));
    opq[3].push_back(mk(1'b0, 3, 5, 4'hF, 32'h0));
    run_drain();

    // Randomised traffic.
    rnd_mode = 1'b1;
    repeat (1500) cycle_drive();
    rnd_mode = 1'b0;
    run_drain();

    // Reset while a read is in flight, then readback of retained contents.
    opq[0].push_back(mk(1'b0, 0, 2, 4'hF, 32'h0));
    cycle_drive();
    do_reset(2);
    for (int i = 0; i < 6; i++)
      for (int p = 0; p < NP; p++) opq[p].push_back(mk(1'b0, p, i, 4'hF, 32'h0));
    run_drain();
    repeat (3) cycle_drive();

    for (int p = 0; p < NP; p++) chk("queue_empty", p, 32'(expq[p].size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
